// File: rtl/pc_sequencer_if.sv
// Request/control bundle between the pipeline and the next-PC sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface pc_sequencer_if;
  logic       stall_req;
  logic       id_jump;
  logic       id_jr;
  logic       ex_branch;
  logic       ex_taken;
  logic       illop;
  logic       irq;
  logic       kernel;
  logic [2:0] PCSrc;
  logic       datahazard;
  logic       flush_ifid;
  logic       flush_idex;
  logic       epc_we;
  logic       irq_ack;

  modport master (
    output stall_req, id_jump, id_jr, ex_branch, ex_taken, illop, irq, kernel,
    input  PCSrc, datahazard, flush_ifid, flush_idex, epc_we, irq_ack
  );

  modport slave (
    input  stall_req, id_jump, id_jr, ex_branch, ex_taken, illop, irq, kernel,
    output PCSrc, datahazard, flush_ifid, flush_idex, epc_we, irq_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC arbiter: priority-selects the redirect source, drives flushes/EPC strobe,
// and defers interrupts for a shadow window after any redirect.
module pc_sequencer #(
  parameter int unsigned SHADOW_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  seq_if
);

  logic       irq_q;
  logic       irq_pend_q, irq_pend_d;
  logic [2:0] shadow_q, shadow_d;

  logic       exc_sel, br_sel, irq_sel, redirect;
  logic [2:0] pc_src;
  logic       hold, flush_ifid, flush_idex, epc_we, irq_ack;

  assign exc_sel = seq_if.illop & ~seq_if.kernel;
  assign br_sel  = seq_if.ex_branch & seq_if.ex_taken;
  assign irq_sel = irq_pend_q & ~seq_if.kernel & (shadow_q == 3'd0) & ~seq_if.stall_req &
                   ~seq_if.ex_branch & ~seq_if.id_jump & ~seq_if.id_jr;

  always_comb begin
    pc_src     = 3'b000;
    hold       = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    epc_we     = 1'b0;
    irq_ack    = 1'b0;
    redirect   = 1'b0;
    if (reset) begin
      pc_src = 3'b000;
    end else if (exc_sel) begin
      pc_src     = 3'b101;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      epc_we     = 1'b1;
      redirect   = 1'b1;
    end else if (br_sel) begin
      pc_src     = 3'b001;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      redirect   = 1'b1;
    end else if (irq_sel) begin
      pc_src     = 3'b100;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      epc_we     = 1'b1;
      irq_ack    = 1'b1;
      redirect   = 1'b1;
    end else if (seq_if.id_jr) begin
      pc_src     = 3'b011;
      flush_ifid = 1'b1;
      redirect   = 1'b1;
    end else if (seq_if.id_jump) begin
      pc_src     = 3'b010;
      flush_ifid = 1'b1;
      redirect   = 1'b1;
    end else if (seq_if.stall_req) begin
      hold = 1'b1;
    end
  end

  // A fresh edge on the same clock as the acknowledge must survive the clear.
  assign irq_pend_d = (seq_if.irq & ~irq_q) | (irq_pend_q & ~irq_ack);

  always_comb begin
    shadow_d = shadow_q;
    if (redirect) begin
      shadow_d = 3'(SHADOW_CYCLES);
    end else if (!hold && shadow_q != 3'd0) begin
      shadow_d = shadow_q - 3'd1;
    end
  end

  // irq_q keeps tracking irq through reset so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    irq_q <= seq_if.irq;
    if (reset) begin
      irq_pend_q <= 1'b0;
      shadow_q   <= 3'd0;
    end else begin
      irq_pend_q <= irq_pend_d;
      shadow_q   <= shadow_d;
    end
  end

  assign seq_if.PCSrc      = pc_src;
  assign seq_if.datahazard = hold;
  assign seq_if.flush_ifid = flush_ifid;
  assign seq_if.flush_idex = flush_idex;
  assign seq_if.epc_we     = epc_we;
  assign seq_if.irq_ack    = irq_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each cycle's output vector
// {PCSrc, datahazard, flush_ifid, flush_idex, epc_we, irq_ack} is compared to a constant.
module tb_pc_sequencer;

  localparam logic [7:0] VSeq   = {3'b000, 5'b00000};
  localparam logic [7:0] VStall = {3'b000, 5'b10000};
  localparam logic [7:0] VBr    = {3'b001, 5'b01100};
  localparam logic [7:0] VJ     = {3'b010, 5'b01000};
  localparam logic [7:0] VJr    = {3'b011, 5'b01000};
  localparam logic [7:0] VIrq   = {3'b100, 5'b01111};
  localparam logic [7:0] VExc   = {3'b101, 5'b01110};
  localparam logic [7:0] VZero  = 8'h00;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .SHADOW_CYCLES(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .seq_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] out_vec;
  assign out_vec = {bus.PCSrc, bus.datahazard, bus.flush_ifid, bus.flush_idex,
                    bus.epc_we, bus.irq_ack};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall_req = 1'b0;
    bus.id_jump   = 1'b0;
    bus.id_jr     = 1'b0;
    bus.ex_branch = 1'b0;
    bus.ex_taken  = 1'b0;
    bus.illop     = 1'b0;
    bus.kernel    = 1'b0;
  endtask

  // Check at the falling edge with current inputs, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check_eq(tag, out_vec, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    bus.irq = 1'b1;
    reset   = 1'b1;
    #1;

    // Reset holds every output low, even with requests present.
    cyc("reset_c0", VZero);
    bus.illop = 1'b1;
    cyc("reset_c1_illop", VZero);
    reset = 1'b0;
    idle();
    // irq held high across reset is not a rising edge.
    for (int i = 0; i < 3; i++) cyc("post_reset_no_irq", VSeq);
    bus.irq = 1'b0;
    cyc("irq_low", VSeq);

    // Taken branch beats stall; its shadow defers the irq raised alongside it.
    bus.stall_req = 1'b1; bus.ex_branch = 1'b1; bus.ex_taken = 1'b1; bus.irq = 1'b1;
    cyc("br_over_stall", VBr);
    idle();
    cyc("br_shadow", VSeq);
    cyc("br_then_irq", VIrq);
    cyc("irq_cleared", VSeq);
    bus.stall_req = 1'b1;
    cyc("stall_only", VStall);
    idle();

    // J with coincident irq edge.
    bus.irq = 1'b0;
    cyc("j_setup", VSeq);
    bus.id_jump = 1'b1; bus.irq = 1'b1;
    cyc("j_sel", VJ);
    idle();
    cyc("j_shadow", VSeq);
    cyc("j_then_irq", VIrq);
    cyc("j_irq_cleared", VSeq);

    // Shadow count freezes while the PC is held.
    bus.irq = 1'b0;
    cyc("frz_setup", VSeq);
    bus.id_jump = 1'b1; bus.irq = 1'b1;
    cyc("frz_j", VJ);
    idle(); bus.stall_req = 1'b1;
    cyc("frz_stall", VStall);
    idle();
    cyc("frz_shadow_kept", VSeq);
    cyc("frz_irq", VIrq);

    // Kernel mode masks a pending interrupt without losing it.
    bus.irq = 1'b0; bus.kernel = 1'b1;
    cyc("kern_setup", VSeq);
    bus.irq = 1'b1;
    for (int i = 0; i < 5; i++) cyc("kern_masked", VSeq);
    bus.kernel = 1'b0;
    cyc("kern_drop_irq", VIrq);
    cyc("kern_after", VSeq);

    // Exception outranks JR and a pending irq; the irq stays pending.
    bus.irq = 1'b0; bus.kernel = 1'b1;
    cyc("exc_setup0", VSeq);
    bus.irq = 1'b1;
    cyc("exc_setup1", VSeq);
    bus.kernel = 1'b0; bus.illop = 1'b1; bus.id_jr = 1'b1;
    cyc("exc_sel", VExc);
    bus.kernel = 1'b1;
    cyc("illop_masked_jr", VJr);
    idle();
    cyc("exc_shadow", VSeq);
    cyc("exc_irq_kept", VIrq);
    cyc("exc_after", VSeq);

    // Not-taken branch blocks the interrupt for that cycle only.
    bus.irq = 1'b0;
    cyc("nt_setup", VSeq);
    bus.irq = 1'b1;
    cyc("nt_edge", VSeq);
    bus.ex_branch = 1'b1;
    cyc("nt_blocks_irq", VSeq);
    idle();
    cyc("nt_then_irq", VIrq);

    // New edge on the acknowledge edge: set wins, so a second irq follows.
    bus.irq = 1'b0;
    cyc("sw_setup", VSeq);
    bus.irq = 1'b1; bus.stall_req = 1'b1;
    cyc("sw_stall0", VStall);
    bus.irq = 1'b0;
    cyc("sw_stall1", VStall);
    bus.irq = 1'b1; bus.stall_req = 1'b0;
    cyc("sw_irq_and_edge", VIrq);
    cyc("sw_shadow", VSeq);
    cyc("sw_second_irq", VIrq);
    cyc("sw_after", VSeq);

    // Reset mid-window with an interrupt pending discards both.
    bus.irq = 1'b0;
    cyc("rst_mid_setup", VSeq);
    bus.id_jump = 1'b1; bus.irq = 1'b1;
    cyc("rst_mid_j", VJ);
    idle(); reset = 1'b1;
    cyc("rst_mid_reset", VZero);
    reset = 1'b0;
    cyc("rst_mid_no_irq0", VSeq);
    cyc("rst_mid_no_irq1", VSeq);

    // Plain sequential run.
    bus.irq = 1'b0;
    for (int i = 0; i < 10; i++) cyc("seq_run", VSeq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
